serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtraction counterpart to the adder cells in the arithmetic library. It serves area-constrained datapaths that can trade latency for a one-bit arithmetic core. Operands are captured on a start handshake; the result is returned with a one-cycle done pulse.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 26 ++
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: bit-serial subtractor FSM states and width limit.
package arith_pkg;

  localparam int SUB_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor (x - y - bin) built from gate primitives, like the adder cells.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire xy_diff;
  wire x_n;
  wire xy_same;
  wire bor_gen;
  wire bor_prop;

  xor g_xor0 (xy_diff, x, y);
  xor g_xor1 (d, xy_diff, bin);

  // Borrow is generated when x=0,y=1 and propagated when x==y.
  not g_not0 (x_n, x);
  and g_and0 (bor_gen, x_n, y);
  not g_not1 (xy_same, xy_diff);
  and g_and1 (bor_prop, xy_same, bin);
  or  g_or0  (bout, bor_gen, bor_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] pd_q, pd_d;
  logic             bor_q, bor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             d_bit;
  logic             bor_n;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (bor_q),
    .d    (d_bit),
    .bout (bor_n)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    pd_d     = pd_q;
    bor_d    = bor_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        bor_d = bor_n;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        pd_d  = {d_bit, pd_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit: publish the full result directly, bypassing pd.
        if (cnt_q == CNT_LAST) begin
          diff_d   = {d_bit, pd_q[WIDTH-1:1]};
          borrow_d = bor_n;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      pd_q     <= '0;
      bor_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      pd_q     <= pd_d;
      bor_q    <= bor_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): operation-level model checked every cycle plus directed literal checks.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int done_cnt = 0;

  // Model state: one outstanding operation and the values the outputs must show.
  logic         m_active = 1'b0;
  int           m_left   = 0;
  logic [W-1:0] m_pdiff  = '0;
  logic         m_pbor   = 1'b0;
  logic         e_busy   = 1'b0;
  logic         e_done   = 1'b0;
  logic [W-1:0] e_diff   = '0;
  logic         e_bor    = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // An operation accepted while idle completes W edges later with (a-b) mod 2^W and a<b.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active <= 1'b0;
      m_left   <= 0;
      e_busy   <= 1'b0;
      e_done   <= 1'b0;
      e_diff   <= '0;
      e_bor    <= 1'b0;
    end else begin
      e_done <= 1'b0;
      if (m_active) begin
        if (m_left == 1) begin
          m_active <= 1'b0;
          e_busy   <= 1'b0;
          e_done   <= 1'b1;
          e_diff   <= m_pdiff;
          e_bor    <= m_pbor;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_left   <= W;
        m_pdiff  <= a - b;
        m_pbor   <= (a < b);
        e_busy   <= 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (cyc > 0) begin
        chk("cmp busy", busy, e_busy);
        chk("cmp done", done, e_done);
        chk("cmp diff", diff, e_diff);
        chk("cmp borrow_out", borrow_out, e_bor);
      end
    end
  end

  task automatic wait_done(output int tcyc);
    tcyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        tcyc = cyc;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] xd, input logic xb, input string nm);
    int t0;
    int td;
    @(posedge clk); #1;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    wait_done(td);
    chk({nm, " latency"}, td - t0, W);
    chk({nm, " diff"}, diff, xd);
    chk({nm, " borrow_out"}, borrow_out, xb);
    @(negedge clk);
    chk({nm, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    int t0;
    int td1;
    int td2;
    int dc0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; a = 8'hAA; b = 8'h11;
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, 8'h00);
    chk("reset borrow_out", borrow_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    do_op(8'h5A, 8'h3C, 8'h1E, 1'b0, "basic");
    do_op(8'h3C, 8'h5A, 8'hE2, 1'b1, "negative");
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, "zero minus one");
    do_op(8'hFF, 8'hFF, 8'h00, 1'b0, "equal");
    do_op(8'h80, 8'h00, 8'h80, 1'b0, "msb only");

    // Start pulse three cycles into RUN must be ignored.
    dc0 = done_cnt;
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy-start busy", busy, 1'b1);
    chk("busy-start diff held", diff, 8'h80);
    wait_done(td1);
    chk("busy-start diff", diff, 8'h1E);
    chk("busy-start borrow_out", borrow_out, 1'b0);
    repeat (12) @(negedge clk);
    chk("busy-start done count", done_cnt - dc0, 1);

    // Back-to-back with start held through the DONE cycle.
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    wait_done(td1);
    chk("b2b first latency", td1 - t0, W);
    chk("b2b first diff", diff, 8'hF0);
    chk("b2b first borrow_out", borrow_out, 1'b1);
    a = 8'h20; b = 8'h10;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(td2);
    chk("b2b spacing", td2 - td1, W + 1);
    chk("b2b second diff", diff, 8'h10);
    chk("b2b second borrow_out", borrow_out, 1'b0);

    // Reset after four RUN edges aborts the operation.
    repeat (2) @(posedge clk);
    dc0 = done_cnt;
    #1 a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 1'b0);
    chk("abort diff", diff, 8'h00);
    chk("abort borrow_out", borrow_out, 1'b0);
    repeat (12) @(negedge clk);
    chk("abort no done", done_cnt - dc0, 0);
    do_op(8'h07, 8'h03, 8'h04, 1'b0, "after abort");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
